io_irq_timer_bank: RTL

Memory-mapped I/O and interrupt block on the cpu6502 bus. It generalises the single legacy 8-bit I/O port into NUM_PORTS output ports, an interrupt status/enable pair, an external interrupt edge detector and a 16-bit reloadable timer. It drives the CPU irq/nmi pins and supplies read data and a chip select to the top-level data-in mux and memory-write gating.

---
 rtl/io_irq_timer_bank_if.sv | 13 +
 rtl/io_irq_timer_bank.sv | 136 +++++++++++++
 2 files changed

// File: rtl/io_irq_timer_bank_if.sv
// CPU-side register bus of io_irq_timer_bank: address/write/data in, read data and chip select out.
interface io_irq_timer_bank_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [ADDR_W-1:0] address;
    logic              write;
    logic [7:0]        data_i;
    logic [7:0]        data_o;
    logic              cs;

    modport master (output address, output write, output data_i, input data_o, input cs);
    modport slave  (input address, input write, input data_i, output data_o, output cs);
endinterface

// File: rtl/io_irq_timer_bank.sv
// Memory-mapped output ports, interrupt status/enable, external edge detect and a 16-bit
// reloadable timer, driving CPU irq/nmi.
module io_irq_timer_bank #(
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'hBFF8,
    parameter int unsigned       NUM_PORTS = 2,
    parameter int unsigned       PRESCALE  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    io_irq_timer_bank_if.slave     bus,
    input  logic                   ext_irq,
    output logic [8*NUM_PORTS-1:0] port_out,
    output logic                   irq,
    output logic                   nmi
);
    localparam logic [15:0] PrescMax = 16'(PRESCALE - 1);

    logic [7:0]  port_q [NUM_PORTS];
    logic [1:0]  status_q, status_d;
    logic [3:0]  enable_q;
    logic [15:0] reload_q, reload_d;
    logic [15:0] counter_q, counter_d;
    logic [15:0] presc_q, presc_d;
    logic        running_q, running_d;
    logic [7:0]  snapshot_q;
    logic        ext_q;

    logic [2:0] offset;
    logic       sel, wr, tick, tmr_set, ext_set;
    logic [1:0] clr;
    logic [7:0] rdata;

    assign offset = bus.address[2:0];
    // Window is 8-aligned, so matching the upper address bits is the full range check.
    assign sel    = bus.address[ADDR_W-1:3] == BASE_ADDR[ADDR_W-1:3];
    assign wr     = sel & bus.write;
    assign tick   = running_q && (presc_q == PrescMax);
    assign ext_set = ext_irq & ~ext_q;
    assign clr    = (wr && offset == 3'd4) ? bus.data_i[1:0] : 2'b00;

    always_comb begin
        counter_d = counter_q;
        reload_d  = reload_q;
        presc_d   = presc_q;
        running_d = running_q;
        tmr_set   = 1'b0;
        if (running_q) begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
        end
        if (tick) begin
            if (counter_q != 16'd0) begin
                counter_d = counter_q - 16'd1;
            end else begin
                tmr_set   = 1'b1;
                counter_d = reload_q;
                running_d = enable_q[3];
            end
        end
        if (wr && offset == 3'd6) begin
            reload_d[7:0] = bus.data_i;
        end
        // A HI write restarts the timer and takes priority over any tick in the same cycle.
        if (wr && offset == 3'd7) begin
            reload_d[15:8] = bus.data_i;
            counter_d      = {bus.data_i, reload_q[7:0]};
            presc_d        = 16'd0;
            running_d      = 1'b1;
        end
        status_d = (status_q & ~clr) | {ext_set, tmr_set};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                port_q[i] <= 8'h00;
            end
            status_q   <= 2'b00;
            enable_q   <= 4'h0;
            reload_q   <= 16'h0000;
            counter_q  <= 16'h0000;
            presc_q    <= 16'h0000;
            running_q  <= 1'b0;
            snapshot_q <= 8'h00;
            ext_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (wr && offset == 3'(i)) begin
                    port_q[i] <= bus.data_i;
                end
            end
            if (wr && offset == 3'd5) begin
                enable_q <= bus.data_i[3:0];
            end
            if (sel && !bus.write && offset == 3'd6) begin
                snapshot_q <= counter_q[15:8];
            end
            status_q  <= status_d;
            reload_q  <= reload_d;
            counter_q <= counter_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            ext_q     <= ext_irq;
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (sel) begin
            case (offset)
                3'd4:    rdata = {6'b0, status_q};
                3'd5:    rdata = {4'b0, enable_q};
                3'd6:    rdata = counter_q[7:0];
                3'd7:    rdata = snapshot_q;
                default: begin
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (offset == 3'(i)) begin
                            rdata = port_q[i];
                        end
                    end
                end
            endcase
        end
    end

    assign bus.data_o = rdata;
    assign bus.cs     = sel;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        assign port_out[8*g +: 8] = port_q[g];
    end

    assign irq = port_q[0][0] | (status_q[0] & enable_q[0] & ~enable_q[2])
               | (status_q[1] & enable_q[1]);
    assign nmi = port_q[0][1] | (status_q[0] & enable_q[0] & enable_q[2]);
endmodule
